sha1_block_sched: RTL and testbench
===================================

SHA1_BLOCK_SCHED -- requirements
Module: sha1_block_sched

Interface
REQ-001 SHALL have parameter TIMEOUT, default 127, max cycles from core_enable to core_done rising before error.
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have ports rq0_valid/rq1_valid  input  1  requester word valid.
REQ-005 SHALL have ports rq0_data/rq1_data  input  32  requester message word.
REQ-006 SHALL have ports rq0_ready/rq1_ready  output  1  word accepted when valid&ready.
REQ-007 SHALL have port core_enable  output  1  one-cycle start pulse to the SHA-1 core.
REQ-008 SHALL have port core_data  output  512  block to core, word i at bits [32i+31:32i].
REQ-009 SHALL have port core_result  input  160  core digest, H0 at bits [159:128] down to H4 at [31:0].
REQ-010 SHALL have port core_done  input  1  core completion level (low while running, high when complete).
REQ-011 SHALL have ports dig_valid output 1, dig_ready input 1  digest handshake.
REQ-012 SHALL have ports dig_data output 160, dig_id output 1, dig_err output 1  digest, requester index, timeout flag.
REQ-013 SHALL have port busy  output 1  high in every state except IDLE.

Function
REQ-014 SHALL implement states IDLE, LOAD, START, ACK, RUN, OUT.
REQ-015 IDLE: if any rqN_valid, SHALL latch grant and go LOAD with word count 0; else stay.
REQ-016 Arbitration SHALL be round-robin: both valid -> requester other than last_grant wins; last_grant resets to 1 so requester 0 wins first tie.
REQ-017 LOAD: only the granted rqN_ready SHALL be high; non-granted ready SHALL be low.
REQ-018 Each LOAD handshake SHALL store rqN_data into core_data word [count], count 0..15 (4-bit).
REQ-019 Handshake at count 15 SHALL move to START; valid gaps in LOAD SHALL stall without timeout.
REQ-020 START: core_enable SHALL be high exactly one cycle, timer cleared, then ACK.
REQ-021 ACK: SHALL wait for core_done==0 (core accepted), then RUN.
REQ-022 RUN: on core_done==1 SHALL capture core_result into dig_data, dig_err=0, go OUT.
REQ-023 Timer SHALL increment each cycle in ACK/RUN; at timer==TIMEOUT SHALL go OUT with dig_data=0, dig_err=1.
REQ-024 core_data SHALL remain stable from last LOAD handshake until leaving RUN.
REQ-025 OUT: dig_valid=1, dig_id=grant, data/err stable until dig_ready; on dig_valid&dig_ready SHALL update last_grant=grant and go IDLE.
REQ-026 dig_ready high on entry to OUT SHALL yield single-cycle dig_valid.
REQ-027 Latency: last word handshake cycle T -> core_enable at T+1; dig_valid one cycle after core_done sampled high in RUN.
REQ-028 New grant SHALL be evaluated only in IDLE, never mid-block; ungranted valid SHALL be held off.
REQ-029 core_done already high when START issued SHALL NOT complete the block (ACK requires low first).

Reset
REQ-030 reset_n low SHALL asynchronously force IDLE, count=0, timer=0, last_grant=1.
REQ-031 During reset: rq0_ready, rq1_ready, core_enable, dig_valid, dig_err, dig_id, busy = 0; dig_data=0; core_data=0.
REQ-032 Reset mid-block SHALL discard partial block and pending digest; no core_enable after release until a full new block loads.

Verification
REQ-033 rq0 streams 16 words of padded "abc" (0x61626380, 0x0 x14, 0x00000018), model core 82 cycles -> dig_data=a9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d, dig_id=0, dig_err=0.
REQ-034 rq0 and rq1 valid same cycle after reset, both continuously -> grants 0,1,0,1; rq1_ready low throughout rq0 block.
REQ-035 Core model never drops core_done -> dig_err=1, dig_data=0 at TIMEOUT (127) cycles after core_enable.
REQ-036 dig_ready held low 10 cycles in OUT -> dig_valid and dig_data stable 10 cycles; no new grant until accepted.
REQ-037 reset_n pulsed low after word 7 of a block -> outputs zero immediately; next 16-word block produces correct digest.
REQ-038 rq0_valid toggled every other cycle in LOAD -> exactly 16 words captured in order, core_enable once.

Source files
------------

// File: rtl/sha1_block_sched_if.sv
// sha1_block_sched_if
//   Bundles every bus of the SHA-1 block scheduler: two 32-bit word
//   requesters, the 512-bit block / 160-bit digest path to the external
//   SHA-1 core, the digest output handshake and the busy flag.
//   Modports:
//     slave  - the scheduler itself (consumes requests, drives core and digest)
//     master - the surrounding system (requesters, core, digest consumer)
interface sha1_block_sched_if;
    logic         rq0_valid;
    logic         rq1_valid;
    logic [31:0]  rq0_data;
    logic [31:0]  rq1_data;
    logic         rq0_ready;
    logic         rq1_ready;
    logic         core_enable;
    logic [511:0] core_data;
    logic [159:0] core_result;
    logic         core_done;
    logic         dig_valid;
    logic         dig_ready;
    logic [159:0] dig_data;
    logic         dig_id;
    logic         dig_err;
    logic         busy;

    modport slave (
        input  rq0_valid, rq1_valid, rq0_data, rq1_data,
        input  core_result, core_done, dig_ready,
        output rq0_ready, rq1_ready, core_enable, core_data,
        output dig_valid, dig_data, dig_id, dig_err, busy
    );

    modport master (
        output rq0_valid, rq1_valid, rq0_data, rq1_data,
        output core_result, core_done, dig_ready,
        input  rq0_ready, rq1_ready, core_enable, core_data,
        input  dig_valid, dig_data, dig_id, dig_err, busy
    );
endinterface

// File: rtl/sha1_block_sched.sv
// sha1_block_sched
//   Round-robin collects one 16-word block from requester 0 or 1, hands it
//   to an external SHA-1 core with a one-cycle enable, waits for the core to
//   acknowledge (core_done low) and complete (core_done high) under a
//   watchdog, then presents the digest with the requester index.
//   Ports:
//     clk      - sole clock, rising edge
//     reset_n  - asynchronous active-low reset
//     bus      - sha1_block_sched_if.slave (requesters, core, digest, busy)
//   Parameter:
//     TIMEOUT  - cycles allowed in ACK/RUN before the block is abandoned
//
//   state | meaning
//   IDLE  | no block in flight; arbitrate between requesters
//   LOAD  | accepting 16 words from the granted requester
//   START | core_enable pulse, watchdog timer cleared
//   ACK   | waiting for core_done low (core took the block)
//   RUN   | waiting for core_done high, or watchdog expiry
//   OUT   | digest presented until dig_ready
module sha1_block_sched #(
    parameter int TIMEOUT = 127
) (
    input  logic              clk,
    input  logic              reset_n,
    sha1_block_sched_if.slave bus
);
    typedef enum logic [2:0] {IDLE, LOAD, START, ACK, RUN, OUT} state_t;

    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TIMER_TC = TW'(TIMEOUT);

    state_t        state;
    state_t        state_nxt;
    logic          grant;
    logic          last_grant;
    logic          pick;
    logic [3:0]    count;
    logic [TW-1:0] timer;
    logic [511:0]  block;
    logic [159:0]  digest;
    logic          err;
    logic          any_valid;
    logic          word_hs;
    logic          timer_tc;

    assign any_valid = bus.rq0_valid | bus.rq1_valid;
    // On a tie the requester that was not served last wins; otherwise
    // whichever one is asking.
    assign pick      = (bus.rq0_valid & bus.rq1_valid) ? ~last_grant : bus.rq1_valid;
    assign word_hs   = (state == LOAD) & (grant ? bus.rq1_valid : bus.rq0_valid);
    assign timer_tc  = (timer == TIMER_TC);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (any_valid) state_nxt = LOAD;
            LOAD:    if (word_hs && count == 4'd15) state_nxt = START;
            START:   state_nxt = ACK;
            ACK:     if (!bus.core_done) state_nxt = RUN;
                     else if (timer_tc)  state_nxt = OUT;
            RUN:     if (bus.core_done || timer_tc) state_nxt = OUT;
            OUT:     if (bus.dig_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant      <= 1'b0;
            last_grant <= 1'b1;
            count      <= 4'd0;
            timer      <= '0;
            block      <= '0;
            digest     <= '0;
            err        <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (any_valid) begin
                        grant <= pick;
                        count <= 4'd0;
                    end
                end
                LOAD: begin
                    if (word_hs) begin
                        block[{count, 5'd0} +: 32] <= grant ? bus.rq1_data : bus.rq0_data;
                        count <= count + 4'd1;
                    end
                end
                START: timer <= '0;
                ACK: begin
                    timer <= timer + 1'b1;
                    // A core that never drops done is abandoned like a hung one.
                    if (bus.core_done && timer_tc) begin
                        digest <= '0;
                        err    <= 1'b1;
                    end
                end
                RUN: begin
                    timer <= timer + 1'b1;
                    if (bus.core_done) begin
                        digest <= bus.core_result;
                        err    <= 1'b0;
                    end else if (timer_tc) begin
                        digest <= '0;
                        err    <= 1'b1;
                    end
                end
                OUT: if (bus.dig_ready) last_grant <= grant;
                default: ;
            endcase
        end
    end

    assign bus.rq0_ready   = (state == LOAD) & ~grant;
    assign bus.rq1_ready   = (state == LOAD) &  grant;
    assign bus.core_enable = (state == START);
    assign bus.core_data   = block;
    assign bus.dig_valid   = (state == OUT);
    assign bus.dig_data    = digest;
    assign bus.dig_id      = grant;
    assign bus.dig_err     = err;
    assign bus.busy        = (state != IDLE);
endmodule

// File: tb/tb_sha1_block_sched.sv
module tb_sha1_block_sched;
    localparam int TIMEOUT = 127;
    localparam logic [159:0] ABC_DIGEST =
        160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    sha1_block_sched_if bus();
    sha1_block_sched #(.TIMEOUT(TIMEOUT)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    typedef struct packed {
        logic [159:0] data;
        logic         id;
        logic         err;
    } exp_t;

    typedef struct {
        bit req;
        int gap;
        int lat;
        bit stuck;
        int hold;
        bit use_abc;
        bit exp_id;
        bit exp_err;
    } vec_t;

    exp_t scb[$];
    logic id_log[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   enables = 0;
    int   accepted = 0;
    int   t_enable = 0;
    int   t_valid = 0;
    int   core_lat = 10;
    bit   core_stuck = 1'b0;
    int   hold_cycles = 0;
    int   overlap = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_vec(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [159:0] sha1_block(input logic [511:0] blk);
        logic [31:0] w [80];
        logic [31:0] a, b, c, d, e, f, k, tmp;
        for (int t = 0; t < 16; t++) w[t] = blk[32*t +: 32];
        for (int t = 16; t < 80; t++) begin
            tmp  = w[t-3] ^ w[t-8] ^ w[t-14] ^ w[t-16];
            w[t] = {tmp[30:0], tmp[31]};
        end
        a = 32'h67452301; b = 32'hEFCDAB89; c = 32'h98BADCFE;
        d = 32'h10325476; e = 32'hC3D2E1F0;
        for (int t = 0; t < 80; t++) begin
            if (t < 20)      begin f = (b & c) | (~b & d);          k = 32'h5A827999; end
            else if (t < 40) begin f = b ^ c ^ d;                   k = 32'h6ED9EBA1; end
            else if (t < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8F1BBCDC; end
            else             begin f = b ^ c ^ d;                   k = 32'hCA62C1D6; end
            tmp = {a[26:0], a[31:27]} + f + e + k + w[t];
            e = d; d = c; c = {b[1:0], b[31:2]}; b = a; a = tmp;
        end
        return {a + 32'h67452301, b + 32'hEFCDAB89, c + 32'h98BADCFE,
                d + 32'h10325476, e + 32'hC3D2E1F0};
    endfunction

    function automatic logic [511:0] rand_block();
        logic [511:0] blk;
        for (int i = 0; i < 16; i++) blk[32*i +: 32] = $urandom;
        return blk;
    endfunction

    task automatic drive(input bit req, input logic v, input logic [31:0] d);
        if (req) begin bus.rq1_valid = v; bus.rq1_data = d; end
        else     begin bus.rq0_valid = v; bus.rq0_data = d; end
    endtask

    // Streams nwords words; the expected digest enters the scoreboard at the
    // handshake of word 15, which is also the order blocks reach the core.
    task automatic send_block(input bit req, input logic [511:0] blk, input int nwords,
                              input int gap, input exp_t e);
        int k;
        for (int i = 0; i < nwords; i++) begin
            drive(req, 1'b1, blk[32*i +: 32]);
            k = 0;
            while (!(req ? bus.rq1_ready : bus.rq0_ready) && k < 2000) begin
                @(negedge clk);
                k++;
            end
            if (k >= 2000) begin
                checks++; errors++;
                $display("FAIL word_wait: requester %0d word %0d never accepted", req, i);
                drive(req, 1'b0, 32'h0);
                return;
            end
            @(negedge clk);
            if (i == 15) begin
                scb.push_back(e);
                chk_bit("enable_latency", bus.core_enable, 1'b1);
            end
            if (gap > 0 && i < nwords - 1) begin
                drive(req, 1'b0, $urandom);
                repeat (gap) @(negedge clk);
            end
        end
        drive(req, 1'b0, 32'h0);
    endtask

    task automatic wait_accepted(input int target);
        int k = 0;
        while (accepted < target && k < 1000) begin
            @(negedge clk);
            k++;
        end
        chk_int("digest_arrived", accepted, target);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    // Core model: takes the block on core_enable, drops done the next cycle,
    // raises it with the digest core_lat cycles later. A stuck core never
    // drops done.
    initial begin
        logic [511:0] blk;
        bus.core_done   = 1'b1;
        bus.core_result = '0;
        forever begin
            @(negedge clk);
            if (bus.core_enable === 1'b1) begin
                enables++;
                t_enable = cyc;
                if (!core_stuck) begin
                    blk = bus.core_data;
                    @(negedge clk);
                    bus.core_done = 1'b0;
                    repeat (core_lat) @(negedge clk);
                    chk_vec("core_data_stable", bus.core_data, blk);
                    bus.core_result = sha1_block(blk);
                    bus.core_done   = 1'b1;
                    @(negedge clk);
                    chk_bit("done_to_valid", bus.dig_valid, 1'b1);
                end
            end
        end
    end

    // Digest consumer and scoreboard checker.
    initial begin
        exp_t         e;
        logic [159:0] snap;
        bus.dig_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.dig_valid !== 1'b1) begin
                bus.dig_ready = (hold_cycles == 0);
            end else begin
                t_valid = cyc;
                snap    = bus.dig_data;
                for (int h = 1; h < hold_cycles; h++) begin
                    @(negedge clk);
                    chk_bit("hold_valid", bus.dig_valid, 1'b1);
                    chk_vec("hold_data", 512'(bus.dig_data), 512'(snap));
                    chk_bit("hold_no_grant", bus.rq0_ready | bus.rq1_ready, 1'b0);
                end
                bus.dig_ready = 1'b1;
                if (scb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL scb_pop: digest %h with no expected entry", bus.dig_data);
                end else begin
                    e = scb.pop_front();
                    chk_vec("dig_data", 512'(bus.dig_data), 512'(e.data));
                    chk_bit("dig_id", bus.dig_id, e.id);
                    chk_bit("dig_err", bus.dig_err, e.err);
                end
                accepted++;
                id_log.push_back(bus.dig_id);
                @(negedge clk);
                chk_bit("valid_single", bus.dig_valid, 1'b0);
                bus.dig_ready = (hold_cycles == 0);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (bus.rq0_ready === 1'b1 && bus.rq1_ready === 1'b1) overlap++;
        end
    end

    initial begin
        repeat (50000) @(posedge clk);
        $display("FAIL watchdog: simulation did not complete, %0d errors so far", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t         vecs [6];
        logic [511:0] blk;
        logic [511:0] abc;
        logic [511:0] cb [4];
        exp_t         e;
        exp_t         ce [4];
        int           en0;
        int           acc0;

        abc = '0;
        abc[31:0]    = 32'h61626380;
        abc[511:480] = 32'h00000018;

        vecs[0] = '{req:1'b0, gap:0, lat:82, stuck:1'b0, hold:0,  use_abc:1'b1, exp_id:1'b0, exp_err:1'b0};
        vecs[1] = '{req:1'b0, gap:1, lat:6,  stuck:1'b0, hold:0,  use_abc:1'b0, exp_id:1'b0, exp_err:1'b0};
        vecs[2] = '{req:1'b1, gap:0, lat:3,  stuck:1'b0, hold:0,  use_abc:1'b0, exp_id:1'b1, exp_err:1'b0};
        vecs[3] = '{req:1'b0, gap:0, lat:4,  stuck:1'b1, hold:0,  use_abc:1'b0, exp_id:1'b0, exp_err:1'b1};
        vecs[4] = '{req:1'b1, gap:2, lat:2,  stuck:1'b0, hold:10, use_abc:1'b0, exp_id:1'b1, exp_err:1'b0};
        vecs[5] = '{req:1'b0, gap:0, lat:20, stuck:1'b0, hold:0,  use_abc:1'b0, exp_id:1'b0, exp_err:1'b0};

        reset_n = 1'b0;
        bus.rq0_valid = 1'b0; bus.rq0_data = '0;
        bus.rq1_valid = 1'b0; bus.rq1_data = '0;
        #12;
        chk_bit("rst_rq0_ready", bus.rq0_ready, 1'b0);
        chk_bit("rst_rq1_ready", bus.rq1_ready, 1'b0);
        chk_bit("rst_core_enable", bus.core_enable, 1'b0);
        chk_bit("rst_dig_valid", bus.dig_valid, 1'b0);
        chk_bit("rst_dig_err", bus.dig_err, 1'b0);
        chk_bit("rst_dig_id", bus.dig_id, 1'b0);
        chk_bit("rst_busy", bus.busy, 1'b0);
        chk_vec("rst_dig_data", 512'(bus.dig_data), '0);
        chk_vec("rst_core_data", bus.core_data, '0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            hold_cycles = vecs[v].hold;
            core_lat    = vecs[v].lat;
            core_stuck  = vecs[v].stuck;
            blk = vecs[v].use_abc ? abc : rand_block();
            e.id   = vecs[v].exp_id;
            e.err  = vecs[v].exp_err;
            e.data = vecs[v].exp_err ? '0 : (vecs[v].use_abc ? ABC_DIGEST : sha1_block(blk));
            en0  = enables;
            acc0 = accepted;
            @(negedge clk);
            send_block(vecs[v].req, blk, 16, vecs[v].gap, e);
            wait_accepted(acc0 + 1);
            chk_int("enable_once", enables - en0, 1);
            if (vecs[v].stuck) begin
                // Timer runs 0..TIMEOUT in ACK/RUN, then OUT is entered.
                chk_bit("timeout_latency",
                        (t_valid - t_enable >= TIMEOUT) && (t_valid - t_enable <= TIMEOUT + 3), 1'b1);
            end
            core_stuck = 1'b0;
        end

        // Reset in the middle of a block.
        hold_cycles = 0;
        core_lat    = 10;
        e = '{data: '0, id: 1'b0, err: 1'b0};
        send_block(1'b0, rand_block(), 8, 0, e);
        chk_bit("mid_busy", bus.busy, 1'b1);
        en0 = enables;
        reset_n = 1'b0;
        #1;
        chk_bit("mid_rst_busy", bus.busy, 1'b0);
        chk_bit("mid_rst_rq0_ready", bus.rq0_ready, 1'b0);
        chk_bit("mid_rst_dig_valid", bus.dig_valid, 1'b0);
        chk_vec("mid_rst_core_data", bus.core_data, '0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk_int("no_enable_after_reset", enables - en0, 0);
        blk  = rand_block();
        e    = '{data: sha1_block(blk), id: 1'b0, err: 1'b0};
        acc0 = accepted;
        send_block(1'b0, blk, 16, 0, e);
        wait_accepted(acc0 + 1);
        chk_int("enable_after_reset_block", enables - en0, 1);

        // Both requesters streaming back to back from reset.
        pulse_reset();
        core_lat = 4;
        overlap  = 0;
        id_log.delete();
        acc0 = accepted;
        for (int i = 0; i < 4; i++) begin
            cb[i] = rand_block();
            ce[i] = '{data: sha1_block(cb[i]), id: i[0], err: 1'b0};
        end
        fork
            begin
                send_block(1'b0, cb[0], 16, 0, ce[0]);
                send_block(1'b0, cb[2], 16, 0, ce[2]);
            end
            begin
                send_block(1'b1, cb[1], 16, 0, ce[1]);
                send_block(1'b1, cb[3], 16, 0, ce[3]);
            end
        join
        wait_accepted(acc0 + 4);
        chk_int("grant_count", id_log.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk_bit("grant_order", (i < id_log.size()) ? id_log[i] : 1'bx, i[0]);
        end
        chk_int("ready_overlap", overlap, 0);
        chk_int("scb_drained", scb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
